// File: rtl/gravity_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gravity_ctrl_pkg
// Description : Shared game package for the gravity controller. Holds the
//               controller state encoding, the default line/lock tuning
//               values and the line-total to level helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gravity_ctrl_pkg;

    // Lines cleared per level step, and gravity ticks a blocked piece rests
    // before it is forced to lock.
    localparam int LINES_PER_LEVEL_DEFAULT = 10;
    localparam int LOCK_TICKS_DEFAULT      = 2;

    // Highest speed level the tick generator understands.
    localparam int LEVEL_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FALL = 3'd1,
        ST_REQ  = 3'd2,
        ST_REST = 3'd3,
        ST_LOCK = 3'd4
    } gc_state_e;

    // min(total / lines_per_level, LEVEL_MAX); the divisor is an elaboration
    // constant at every call site so this folds to fixed logic.
    function automatic logic [2:0] level_of(input logic [7:0] total,
                                            input int lines_per_level);
        int q;
        q = int'(total) / lines_per_level;
        if (q > LEVEL_MAX) begin
            q = LEVEL_MAX;
        end
        return q[2:0];
    endfunction

endpackage : gravity_ctrl_pkg
`default_nettype wire

// File: rtl/gravity_ctrl_level_tracker.sv
`default_nettype none
// ============================================================================
// Module      : level_tracker
// Description : Accumulates cleared lines into a saturating 8-bit total and
//               derives the registered speed level from it.
// Ports       : CLK           in   system clock
//               RESET         in   asynchronous active-low reset
//               lines_valid   in   qualifies lines_cleared for one cycle
//               lines_cleared in   rows cleared by the last lock (0-4)
//               level         out  min(total / LINES_PER_LEVEL, 7)
// Revision    : 1.0 - initial release
// ============================================================================
module level_tracker
    import gravity_ctrl_pkg::*;
#(
    parameter int LINES_PER_LEVEL = LINES_PER_LEVEL_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       lines_valid,
    input  logic [2:0] lines_cleared,
    output logic [2:0] level
);

    logic [7:0] total_q;
    logic [7:0] total_d;
    logic [2:0] level_q;
    logic [2:0] level_d;
    logic [8:0] w_sum;

    always_comb begin
        w_sum   = {1'b0, total_q} + {6'b0, lines_cleared};
        total_d = total_q;
        if (lines_valid) begin
            // Carry out of bit 7 means the total would pass 255: clamp.
            total_d = w_sum[8] ? 8'hFF : w_sum[7:0];
        end
        // Level follows the registered total, so it lands one cycle after
        // the total changes.
        level_d = level_of(total_q, LINES_PER_LEVEL);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            total_q <= 8'd0;
            level_q <= 3'd0;
        end else begin
            total_q <= total_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule : level_tracker
`default_nettype wire

// File: rtl/gravity_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gravity_ctrl
// Description : Piece gravity controller. Sequences spawn, falling, resting
//               and locking of the active piece against the board, tracks
//               hard/soft drop selection and the speed level.
// Ports       : CLK           in   system clock
//               RESET         in   asynchronous active-low reset
//               piece_clk     in   one-cycle gravity tick
//               spawn         in   new piece placed on the board
//               key_down      in   soft-drop held (level)
//               key_hard      in   hard-drop press pulse
//               fall_ack      in   board accepted fall_req
//               fall_blocked  in   with fall_ack: move-down failed
//               lock_ack      in   board merged the piece
//               lines_valid   in   qualifies lines_cleared
//               lines_cleared in   rows cleared by last lock
//               drop          out  soft-drop select to tick generator
//               hard_drop     out  hard-drop select to tick generator
//               level         out  speed level 0-7
//               fall_req      out  move-down request, held until fall_ack
//               lock_req      out  lock request, held until lock_ack
// Revision    : 1.0 - initial release
// ============================================================================
module gravity_ctrl
    import gravity_ctrl_pkg::*;
#(
    parameter int LINES_PER_LEVEL = LINES_PER_LEVEL_DEFAULT,
    parameter int LOCK_TICKS      = LOCK_TICKS_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       piece_clk,
    input  logic       spawn,
    input  logic       key_down,
    input  logic       key_hard,
    input  logic       fall_ack,
    input  logic       fall_blocked,
    input  logic       lock_ack,
    input  logic       lines_valid,
    input  logic [2:0] lines_cleared,
    output logic       drop,
    output logic       hard_drop,
    output logic [2:0] level,
    output logic       fall_req,
    output logic       lock_req
);

    localparam int REST_W = (LOCK_TICKS < 1) ? 1 : $clog2(LOCK_TICKS + 1);
    localparam logic [REST_W-1:0] REST_MAX = REST_W'(LOCK_TICKS);

    gc_state_e         state_q;
    gc_state_e         state_d;
    logic [REST_W-1:0] rest_q;
    logic [REST_W-1:0] rest_d;
    logic              hard_q;
    logic              hard_d;
    logic              drop_q;
    logic              drop_d;
    logic              fall_req_q;
    logic              fall_req_d;
    logic              lock_req_q;
    logic              lock_req_d;

    always_comb begin
        state_d = state_q;
        rest_d  = rest_q;
        hard_d  = hard_q;

        unique case (state_q)
            ST_IDLE: begin
                if (spawn) begin
                    state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (key_hard) begin
                    hard_d = 1'b1;
                end
                if (piece_clk) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A hard press in the same cycle as a blocked ack already
                // counts, so the piece goes straight to LOCK.
                if (key_hard) begin
                    hard_d = 1'b1;
                end
                if (fall_ack) begin
                    if (!fall_blocked) begin
                        state_d = ST_FALL;
                        rest_d  = '0;
                    end else if (!hard_d && (rest_q < REST_MAX)) begin
                        state_d = ST_REST;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_REST: begin
                if (key_hard) begin
                    state_d = ST_LOCK;
                end else if (piece_clk) begin
                    state_d = ST_REQ;
                    if (rest_q != REST_MAX) begin
                        rest_d = rest_q + 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                if (lock_ack) begin
                    state_d = ST_IDLE;
                    hard_d  = 1'b0;
                    rest_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are valid in the
        // very cycle a state is entered.
        fall_req_d = (state_d == ST_REQ);
        lock_req_d = (state_d == ST_LOCK);
        drop_d     = key_down && !hard_d &&
                     ((state_d == ST_FALL) || (state_d == ST_REQ) ||
                      (state_d == ST_REST));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            rest_q     <= '0;
            hard_q     <= 1'b0;
            drop_q     <= 1'b0;
            fall_req_q <= 1'b0;
            lock_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rest_q     <= rest_d;
            hard_q     <= hard_d;
            drop_q     <= drop_d;
            fall_req_q <= fall_req_d;
            lock_req_q <= lock_req_d;
        end
    end

    assign drop      = drop_q;
    assign hard_drop = hard_q;
    assign fall_req  = fall_req_q;
    assign lock_req  = lock_req_q;

    level_tracker #(
        .LINES_PER_LEVEL (LINES_PER_LEVEL)
    ) u_level (
        .CLK           (CLK),
        .RESET         (RESET),
        .lines_valid   (lines_valid),
        .lines_cleared (lines_cleared),
        .level         (level)
    );

endmodule : gravity_ctrl
`default_nettype wire

// File: tb/tb_gravity_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gravity_ctrl
// Description : Self-checking bench for gravity_ctrl: directed scenarios plus
//               randomized play against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gravity_ctrl;

    localparam int LPL = 10;
    localparam int LT  = 2;

    // Piece phases of the reference model.
    localparam int M_IDLE = 0;
    localparam int M_FALL = 1;
    localparam int M_REQ  = 2;
    localparam int M_REST = 3;
    localparam int M_LOCK = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       piece_clk = 1'b0;
    logic       spawn = 1'b0;
    logic       key_down = 1'b0;
    logic       key_hard = 1'b0;
    logic       fall_ack = 1'b0;
    logic       fall_blocked = 1'b0;
    logic       lock_ack = 1'b0;
    logic       lines_valid = 1'b0;
    logic [2:0] lines_cleared = 3'd0;
    logic       drop;
    logic       hard_drop;
    logic [2:0] level;
    logic       fall_req;
    logic       lock_req;

    int n_vec = 0;
    int n_err = 0;

    gravity_ctrl #(
        .LINES_PER_LEVEL (LPL),
        .LOCK_TICKS      (LT)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .piece_clk     (piece_clk),
        .spawn         (spawn),
        .key_down      (key_down),
        .key_hard      (key_hard),
        .fall_ack      (fall_ack),
        .fall_blocked  (fall_blocked),
        .lock_ack      (lock_ack),
        .lines_valid   (lines_valid),
        .lines_cleared (lines_cleared),
        .drop          (drop),
        .hard_drop     (hard_drop),
        .level         (level),
        .fall_req      (fall_req),
        .lock_req      (lock_req)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: piece phase, rest count, hard latch, line total,
    // level and the soft-drop output, advanced once per clock.
    // ------------------------------------------------------------------
    typedef struct {
        int st;
        int rest;
        bit hard;
        int total;
        int level;
        bit drop;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t model_next(mdl_t m, bit sp, bit pc, bit kd,
                                        bit kh, bit fa, bit fb, bit la,
                                        bit lv, int lc);
        mdl_t n;
        n = m;
        if (kh && (m.st == M_FALL || m.st == M_REQ)) n.hard = 1'b1;
        if (m.st == M_IDLE) begin
            if (sp) n.st = M_FALL;
        end else if (m.st == M_FALL) begin
            if (pc) n.st = M_REQ;
        end else if (m.st == M_REQ) begin
            if (fa && !fb) begin
                n.st = M_FALL;
                n.rest = 0;
            end else if (fa) begin
                n.st = (!n.hard && m.rest < LT) ? M_REST : M_LOCK;
            end
        end else if (m.st == M_REST) begin
            if (kh) begin
                n.st = M_LOCK;
            end else if (pc) begin
                n.st = M_REQ;
                n.rest = (m.rest + 1 > LT) ? LT : m.rest + 1;
            end
        end else begin
            if (la) begin
                n.st = M_IDLE;
                n.hard = 1'b0;
                n.rest = 0;
            end
        end
        n.level = (m.total / LPL > 7) ? 7 : m.total / LPL;
        if (lv) n.total = (m.total + lc > 255) ? 255 : m.total + lc;
        n.drop = kd && !n.hard && (n.st == M_FALL || n.st == M_REQ || n.st == M_REST);
        return n;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mdl <= '{st: M_IDLE, rest: 0, hard: 1'b0, total: 0, level: 0, drop: 1'b0};
        end else begin
            mdl <= model_next(mdl, spawn, piece_clk, key_down, key_hard, fall_ack,
                              fall_blocked, lock_ack, lines_valid, int'(lines_cleared));
        end
    end

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        piece_clk = 1'b0; spawn = 1'b0; key_down = 1'b0; key_hard = 1'b0;
        fall_ack = 1'b0; fall_blocked = 1'b0; lock_ack = 1'b0;
        lines_valid = 1'b0; lines_cleared = 3'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        RESET = 1'b0;
        tick();
        n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", drop); end
        n_vec++; if (hard_drop !== 1'b0) begin n_err++; $display("FAIL reset_hard_drop: got %b want 0", hard_drop); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL reset_fall_req: got %b want 0", fall_req); end
        n_vec++; if (lock_req !== 1'b0) begin n_err++; $display("FAIL reset_lock_req: got %b want 0", lock_req); end
        RESET = 1'b1;
        tick();
        // piece_clk without a spawn must not start a fall
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL idle_ignores_clk: got %b want 0", fall_req); end
    endtask

    task automatic test_fall();
        do_reset();
        spawn = 1'b1; tick(); spawn = 1'b0;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL fall_req_after_spawn: got %b want 0", fall_req); end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL fall_req_after_clk: got %b want 1", fall_req); end
        tick();
        n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL fall_req_held: got %b want 1", fall_req); end
        fall_ack = 1'b1; fall_blocked = 1'b0; tick(); fall_ack = 1'b0;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL fall_req_after_ack: got %b want 0", fall_req); end
        // back in FALL: the next tick requests again
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL fall_req_second: got %b want 1", fall_req); end
        fall_ack = 1'b1; tick(); fall_ack = 1'b0;
    endtask

    task automatic test_blocked();
        do_reset();
        spawn = 1'b1; tick(); spawn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            piece_clk = 1'b1; tick(); piece_clk = 1'b0;
            n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL blk_fall_req[%0d]: got %b want 1", i, fall_req); end
            fall_ack = 1'b1; fall_blocked = 1'b1; tick(); fall_ack = 1'b0; fall_blocked = 1'b0;
            n_vec++; if (lock_req !== (i == 2)) begin n_err++; $display("FAIL blk_lock_req[%0d]: got %b want %b", i, lock_req, (i == 2)); end
        end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b0 || lock_req !== 1'b1) begin n_err++; $display("FAIL lock_drops_clk: got fr=%b lr=%b want fr=0 lr=1", fall_req, lock_req); end
        lock_ack = 1'b1; tick(); lock_ack = 1'b0;
        n_vec++; if (lock_req !== 1'b0) begin n_err++; $display("FAIL lock_req_after_ack: got %b want 0", lock_req); end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL idle_after_lock: got %b want 0", fall_req); end
    endtask

    task automatic test_hard();
        do_reset();
        key_down = 1'b1;
        spawn = 1'b1; tick(); spawn = 1'b0;
        n_vec++; if (drop !== 1'b1) begin n_err++; $display("FAIL soft_drop: got %b want 1", drop); end
        key_hard = 1'b1; tick(); key_hard = 1'b0;
        n_vec++; if (hard_drop !== 1'b1 || drop !== 1'b0) begin n_err++; $display("FAIL hard_set: got hd=%b d=%b want hd=1 d=0", hard_drop, drop); end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        fall_ack = 1'b1; fall_blocked = 1'b1; tick(); fall_ack = 1'b0; fall_blocked = 1'b0;
        n_vec++; if (lock_req !== 1'b1 || hard_drop !== 1'b1) begin n_err++; $display("FAIL hard_lock: got lr=%b hd=%b want lr=1 hd=1", lock_req, hard_drop); end
        lock_ack = 1'b1; tick(); lock_ack = 1'b0;
        n_vec++; if (hard_drop !== 1'b0 || lock_req !== 1'b0 || drop !== 1'b0) begin n_err++; $display("FAIL hard_clear: got hd=%b lr=%b d=%b want 0 0 0", hard_drop, lock_req, drop); end
        key_down = 1'b0;
    endtask

    task automatic test_lines();
        int t;
        int exp_lvl;
        do_reset();
        t = 0;
        for (int i = 0; i < 3; i++) begin
            lines_valid = 1'b1; lines_cleared = 3'd4; tick();
            t += 4;
        end
        lines_valid = 1'b0; lines_cleared = 3'd0;
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL level_lag: got %0d want 0", level); end
        tick();
        n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL level_12: got %0d want 1", level); end
        // climb to 252 one pulse at a time; level reflects the previous total
        for (int i = 0; i < 60; i++) begin
            exp_lvl = (t / LPL > 7) ? 7 : t / LPL;
            lines_valid = 1'b1; lines_cleared = 3'd4; tick();
            t += 4;
            n_vec++; if (level !== 3'(exp_lvl)) begin n_err++; $display("FAIL level_climb[%0d]: got %0d want %0d", i, level, exp_lvl); end
        end
        lines_valid = 1'b1; lines_cleared = 3'd2; tick();    // 254
        lines_valid = 1'b1; lines_cleared = 3'd4; tick();    // saturates at 255
        lines_valid = 1'b0; lines_cleared = 3'd0;
        tick();
        n_vec++; if (level !== 3'd7) begin n_err++; $display("FAIL level_sat: got %0d want 7", level); end
        lines_valid = 1'b1; lines_cleared = 3'd4; tick();
        lines_valid = 1'b0; lines_cleared = 3'd0;
        tick();
        n_vec++; if (level !== 3'd7) begin n_err++; $display("FAIL level_sat2: got %0d want 7", level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spawn = 1'b1; tick(); spawn = 1'b0;
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %b want 1", fall_req); end
        #2;
        RESET = 1'b0;
        #1;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL mid_async: got %b want 0", fall_req); end
        #3;
        RESET = 1'b1;
        fall_ack = 1'b1; tick(); fall_ack = 1'b0;
        n_vec++; if (fall_req !== 1'b0 || lock_req !== 1'b0) begin n_err++; $display("FAIL mid_late_ack: got fr=%b lr=%b want 0 0", fall_req, lock_req); end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL mid_idle: got %b want 0", fall_req); end
    endtask

    task automatic test_spurious();
        do_reset();
        spawn = 1'b1; tick(); spawn = 1'b0;
        piece_clk = 1'b1; tick();
        tick(); piece_clk = 1'b0;            // second tick lands in REQ
        fall_ack = 1'b1; tick(); fall_ack = 1'b0;
        tick();
        n_vec++; if (fall_req !== 1'b0) begin n_err++; $display("FAIL clk_not_queued: got %b want 0", fall_req); end
        spawn = 1'b1; tick(); spawn = 1'b0;
        n_vec++; if (fall_req !== 1'b0 || lock_req !== 1'b0) begin n_err++; $display("FAIL spawn_in_fall: got fr=%b lr=%b want 0 0", fall_req, lock_req); end
        piece_clk = 1'b1; tick(); piece_clk = 1'b0;
        n_vec++; if (fall_req !== 1'b1) begin n_err++; $display("FAIL still_fall: got %b want 1", fall_req); end
        fall_ack = 1'b1; tick(); fall_ack = 1'b0;
    endtask

    task automatic test_random();
        bit e_fr, e_lr, e_hd, e_dr;
        int e_lv;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            spawn         = ($urandom_range(0, 3) == 0);
            piece_clk     = ($urandom_range(0, 2) == 0);
            key_down      = ($urandom_range(0, 1) == 0);
            fall_ack      = (mdl.st == M_REQ) && ($urandom_range(0, 2) == 0);
            fall_blocked  = ($urandom_range(0, 1) == 0);
            lock_ack      = (mdl.st == M_LOCK) && ($urandom_range(0, 2) == 0);
            key_hard      = !piece_clk && !fall_ack && ($urandom_range(0, 11) == 0);
            lines_valid   = ($urandom_range(0, 15) == 0);
            lines_cleared = 3'($urandom_range(0, 4));
            tick();
            e_fr = (mdl.st == M_REQ);
            e_lr = (mdl.st == M_LOCK);
            e_hd = mdl.hard;
            e_dr = mdl.drop;
            e_lv = mdl.level;
            n_vec++; if (fall_req !== e_fr) begin n_err++; $display("FAIL rnd_fall_req @%0d: got %b want %b", i, fall_req, e_fr); end
            n_vec++; if (lock_req !== e_lr) begin n_err++; $display("FAIL rnd_lock_req @%0d: got %b want %b", i, lock_req, e_lr); end
            n_vec++; if (hard_drop !== e_hd) begin n_err++; $display("FAIL rnd_hard_drop @%0d: got %b want %b", i, hard_drop, e_hd); end
            n_vec++; if (drop !== e_dr) begin n_err++; $display("FAIL rnd_drop @%0d: got %b want %b", i, drop, e_dr); end
            n_vec++; if (level !== 3'(e_lv)) begin n_err++; $display("FAIL rnd_level @%0d: got %0d want %0d", i, level, e_lv); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fall();
        test_blocked();
        test_hard();
        test_lines();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gravity_ctrl
`default_nettype wire
